// File: rtl/hsid_x_ctrl_regs.sv
// HSID-X control/status register block: job configuration, start/clear pulses, status and MSE readback.
// Optional bus monitor (simulation only) is compiled in when HSID_X_CTRL_REG_DEBUG_EN is defined.
package hsid_x_reg_pkg;
  localparam int HSID_WORD_WIDTH        = 32;
  localparam int HSID_HSP_BANDS_WIDTH   = 9;
  localparam int HSID_HSP_LIBRARY_WIDTH = 13;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [3:0] {
    HSID_X_CTRL_STATUS              = 4'd0,
    HSID_X_CTRL_LIBRARY_SIZE        = 4'd1,
    HSID_X_CTRL_PIXEL_BANDS         = 4'd2,
    HSID_X_CTRL_CAPTURED_PIXEL_ADDR = 4'd3,
    HSID_X_CTRL_LIBRARY_PIXEL_ADDR  = 4'd4,
    HSID_X_CTRL_MSE_MIN_REF         = 4'd5,
    HSID_X_CTRL_MSE_MIN_VALUE       = 4'd6,
    HSID_X_CTRL_MSE_MAX_REF         = 4'd7,
    HSID_X_CTRL_MSE_MAX_VALUE       = 4'd8
  } hsid_x_ctrl_id_e;
endpackage

module hsid_x_ctrl_regs
  import hsid_x_reg_pkg::*;
#(
  parameter int WORD_WIDTH        = HSID_WORD_WIDTH,
  parameter int HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
  parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  reg_req_t                     reg_req,
  output reg_rsp_t                     reg_rsp,
  output logic                         start,
  output logic                         clear,
  input  logic                         idle,
  input  logic                         ready,
  input  logic                         done,
  input  logic                         error,
  output logic [HSP_LIBRARY_WIDTH-1:0] library_size,
  output logic [HSP_BANDS_WIDTH-1:0]   pixel_bands,
  output logic [WORD_WIDTH-1:0]        captured_pixel_addr,
  output logic [WORD_WIDTH-1:0]        library_pixel_addr,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_min_ref,
  input  logic [HSP_LIBRARY_WIDTH-1:0] mse_max_ref,
  input  logic [WORD_WIDTH-1:0]        mse_min_value,
  input  logic [WORD_WIDTH-1:0]        mse_max_value
);

  logic                         addr_ok;
  logic                         wr_en;
  logic                         rd_en;
  hsid_x_ctrl_id_e              reg_id;
  logic [31:0]                  wmask;
  logic                         start_reg;
  logic                         clear_reg;
  logic [HSP_LIBRARY_WIDTH-1:0] library_size_reg;
  logic [HSP_BANDS_WIDTH-1:0]   pixel_bands_reg;
  logic [WORD_WIDTH-1:0]        captured_pixel_addr_reg;
  logic [WORD_WIDTH-1:0]        library_pixel_addr_reg;

  // Only word-aligned offsets up to the last MSE register decode; the rest raise error.
  assign addr_ok = (reg_req.addr[1:0] == 2'b00) && (reg_req.addr <= 32'h20);
  assign wr_en   = reg_req.valid & reg_req.write & addr_ok;
  assign rd_en   = reg_req.valid & ~reg_req.write & addr_ok;
  assign reg_id  = hsid_x_ctrl_id_e'(reg_req.addr[5:2]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
    assign wmask[8*gi +: 8] = {8{reg_req.wstrb[gi]}};
  end

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_reg               <= 1'b0;
      clear_reg               <= 1'b0;
      library_size_reg        <= '0;
      pixel_bands_reg         <= '0;
      captured_pixel_addr_reg <= '0;
      library_pixel_addr_reg  <= '0;
    end else begin
      start_reg <= wr_en && (reg_id == HSID_X_CTRL_STATUS) && reg_req.wstrb[0] && reg_req.wdata[0];
      clear_reg <= wr_en && (reg_id == HSID_X_CTRL_STATUS) && reg_req.wstrb[0] && reg_req.wdata[4];
      if (wr_en) begin
        case (reg_id)
          HSID_X_CTRL_LIBRARY_SIZE:
            library_size_reg <= HSP_LIBRARY_WIDTH'(merge(32'(library_size_reg), reg_req.wdata, wmask));
          HSID_X_CTRL_PIXEL_BANDS:
            pixel_bands_reg <= HSP_BANDS_WIDTH'(merge(32'(pixel_bands_reg), reg_req.wdata, wmask));
          HSID_X_CTRL_CAPTURED_PIXEL_ADDR:
            captured_pixel_addr_reg <= WORD_WIDTH'(merge(32'(captured_pixel_addr_reg), reg_req.wdata, wmask));
          HSID_X_CTRL_LIBRARY_PIXEL_ADDR:
            library_pixel_addr_reg <= WORD_WIDTH'(merge(32'(library_pixel_addr_reg), reg_req.wdata, wmask));
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    reg_rsp       = '0;
    reg_rsp.ready = 1'b1;
    reg_rsp.error = reg_req.valid & ~addr_ok;
    if (rd_en) begin
      case (reg_id)
        HSID_X_CTRL_STATUS:              reg_rsp.rdata = 32'({error, 1'b0, done, ready, idle, 1'b0});
        HSID_X_CTRL_LIBRARY_SIZE:        reg_rsp.rdata = 32'(library_size_reg);
        HSID_X_CTRL_PIXEL_BANDS:         reg_rsp.rdata = 32'(pixel_bands_reg);
        HSID_X_CTRL_CAPTURED_PIXEL_ADDR: reg_rsp.rdata = 32'(captured_pixel_addr_reg);
        HSID_X_CTRL_LIBRARY_PIXEL_ADDR:  reg_rsp.rdata = 32'(library_pixel_addr_reg);
        HSID_X_CTRL_MSE_MIN_REF:         reg_rsp.rdata = 32'(mse_min_ref);
        HSID_X_CTRL_MSE_MIN_VALUE:       reg_rsp.rdata = 32'(mse_min_value);
        HSID_X_CTRL_MSE_MAX_REF:         reg_rsp.rdata = 32'(mse_max_ref);
        HSID_X_CTRL_MSE_MAX_VALUE:       reg_rsp.rdata = 32'(mse_max_value);
        default:                         reg_rsp.rdata = '0;
      endcase
    end
  end

  assign start               = start_reg;
  assign clear               = clear_reg;
  assign library_size        = library_size_reg;
  assign pixel_bands         = pixel_bands_reg;
  assign captured_pixel_addr = captured_pixel_addr_reg;
  assign library_pixel_addr  = library_pixel_addr_reg;

`ifdef HSID_X_CTRL_REG_DEBUG_EN
  always_ff @(posedge clk) begin
    if (reg_req.valid) begin
      $display("%0t hsid_x_ctrl_regs %s addr=%08h data=%08h err=%0b", $time,
               reg_req.write ? "W" : "R", reg_req.addr,
               reg_req.write ? reg_req.wdata : reg_rsp.rdata, reg_rsp.error);
      if (!reg_rsp.ready) $error("hsid_x_ctrl_regs: ready low during valid access");
    end
  end
`else
  // No bus monitor in this build.
`endif

endmodule

// File: tb/tb_hsid_x_ctrl_regs.sv
// Directed self-checking bench for hsid_x_ctrl_regs: one line per bus transaction, summary at end.
module tb_hsid_x_ctrl_regs;
  import hsid_x_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  reg_req_t    reg_req;
  reg_rsp_t    reg_rsp;
  logic        start, clear;
  logic        idle = 1'b0, ready = 1'b0, done = 1'b0, error = 1'b0;
  logic [12:0] library_size;
  logic [8:0]  pixel_bands;
  logic [31:0] captured_pixel_addr, library_pixel_addr;
  logic [12:0] mse_min_ref = '0, mse_max_ref = '0;
  logic [31:0] mse_min_value = '0, mse_max_value = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  hsid_x_ctrl_regs dut (
    .clk(clk), .rst_n(rst_n), .reg_req(reg_req), .reg_rsp(reg_rsp),
    .start(start), .clear(clear), .idle(idle), .ready(ready), .done(done), .error(error),
    .library_size(library_size), .pixel_bands(pixel_bands),
    .captured_pixel_addr(captured_pixel_addr), .library_pixel_addr(library_pixel_addr),
    .mse_min_ref(mse_min_ref), .mse_max_ref(mse_max_ref),
    .mse_min_value(mse_min_value), .mse_max_value(mse_max_value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access: drive at negedge, sample the response mid-cycle, retire after the posedge.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    reg_req.valid = 1'b1;
    reg_req.write = wr;
    reg_req.addr  = addr;
    reg_req.wdata = data;
    reg_req.wstrb = strb;
    #1;
    rdata = reg_rsp.rdata;
    err   = reg_rsp.error;
    $display("%0t %s addr=%08h wdata=%08h strb=%h rdata=%08h err=%0b", $time,
             wr ? "WR" : "RD", addr, data, strb, rdata, err);
    @(posedge clk);
    #1;
    reg_req = '0;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    access(1'b1, addr, data, 4'hF, rd, er);
  endtask

  task automatic rd32(input logic [31:0] addr);
    access(1'b0, addr, 32'h0, 4'h0, rd, er);
  endtask

  initial begin
    reg_req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(start), 32'h0);
    check("rst_clear", 32'(clear), 32'h0);
    check("rst_libsize", 32'(library_size), 32'h0);
    check("rst_capaddr", captured_pixel_addr, 32'h0);
    rst_n = 1'b1;

    wr32(32'h04, 32'd10);
    check("libsize_10", 32'(library_size), 32'd10);
    wr32(32'h04, 32'hFFFF_FFFF);
    check("libsize_max", 32'(library_size), 32'd8191);
    rd32(32'h04);
    check("libsize_rd", rd, 32'h0000_1FFF);
    check("libsize_rd_err", 32'(er), 32'h0);
    wr32(32'h08, 32'd5);
    check("bands_5", 32'(pixel_bands), 32'd5);
    wr32(32'h08, 32'hFFFF_FFFF);
    check("bands_max", 32'(pixel_bands), 32'd511);
    rd32(32'h08);
    check("bands_rd", rd, 32'h0000_01FF);
    wr32(32'h0C, 32'h1234_5678);
    check("capaddr", captured_pixel_addr, 32'h1234_5678);
    wr32(32'h10, 32'h8765_4321);
    check("libaddr", library_pixel_addr, 32'h8765_4321);
    rd32(32'h0C);
    check("capaddr_rd", rd, 32'h1234_5678);
    rd32(32'h10);
    check("libaddr_rd", rd, 32'h8765_4321);
    access(1'b1, 32'h10, 32'hAAAA_AAAA, 4'b0010, rd, er);
    check("libaddr_strb", library_pixel_addr, 32'h8765_AA21);

    // Pulses: back-to-back start then clear, then both, then a mixed pattern.
    wr32(32'h00, 32'h01);
    check("p1_start", 32'(start), 32'h1);
    check("p1_clear", 32'(clear), 32'h0);
    wr32(32'h00, 32'h10);
    check("p2_start", 32'(start), 32'h0);
    check("p2_clear", 32'(clear), 32'h1);
    @(posedge clk); #1;
    check("p2_clear_end", 32'(clear), 32'h0);
    wr32(32'h00, 32'h11);
    check("p3_both", {30'h0, start, clear}, 32'h3);
    @(posedge clk); #1;
    check("p3_end", {30'h0, start, clear}, 32'h0);
    wr32(32'h00, 32'hA5A5_A5A5);
    check("p4_mixed", {30'h0, start, clear}, 32'h2);
    access(1'b1, 32'h00, 32'h11, 4'b1110, rd, er);
    check("p5_nostrb", {30'h0, start, clear}, 32'h0);
    rd32(32'h00);
    check("status_pulse_rd", rd, 32'h0);

    // Status bits: on one at a time, then off one at a time.
    idle = 1'b1;  rd32(32'h00); check("st_02", rd, 32'h02);
    ready = 1'b1; rd32(32'h00); check("st_06", rd, 32'h06);
    done = 1'b1;  rd32(32'h00); check("st_0e", rd, 32'h0E);
    error = 1'b1; rd32(32'h00); check("st_2e", rd, 32'h2E);
    idle = 1'b0;  rd32(32'h00); check("st_2c", rd, 32'h2C);
    ready = 1'b0; rd32(32'h00); check("st_28", rd, 32'h28);
    done = 1'b0;  rd32(32'h00); check("st_20", rd, 32'h20);
    error = 1'b0; rd32(32'h00); check("st_00", rd, 32'h00);

    mse_min_ref = 13'h0ABC; mse_min_value = 32'hDEAD_BEEF;
    mse_max_ref = 13'h1FFF; mse_max_value = 32'h0000_0042;
    rd32(32'h14); check("min_ref", rd, 32'h0000_0ABC);
    rd32(32'h18); check("min_val", rd, 32'hDEAD_BEEF);
    rd32(32'h1C); check("max_ref", rd, 32'h0000_1FFF);
    rd32(32'h20); check("max_val", rd, 32'h0000_0042);
    wr32(32'h14, 32'h0000_0001);
    check("ro_wr_err", 32'(er), 32'h0);
    rd32(32'h14); check("ro_unchanged", rd, 32'h0000_0ABC);

    rd32(32'h40);
    check("bad_err", 32'(er), 32'h1);
    check("bad_rdata", rd, 32'h0);
    check("bad_ready", 32'(reg_rsp.ready), 32'h1);
    wr32(32'h06, 32'h0000_0077);
    check("misalign_err", 32'(er), 32'h1);
    check("misalign_noeff", 32'(pixel_bands), 32'd511);
    wr32(32'h24, 32'h0000_0011);
    check("oob_err", 32'(er), 32'h1);
    check("oob_nopulse", {30'h0, start, clear}, 32'h0);

    // Reset with a concurrent write: everything RW returns to 0 and the write is lost.
    rst_n = 1'b0;
    wr32(32'h04, 32'd7);
    rst_n = 1'b1;
    rd32(32'h04); check("rst2_libsize", rd, 32'h0);
    rd32(32'h08); check("rst2_bands", rd, 32'h0);
    rd32(32'h0C); check("rst2_capaddr", rd, 32'h0);
    rd32(32'h10); check("rst2_libaddr", rd, 32'h0);
    check("rst2_pulses", {30'h0, start, clear}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
